// File: rtl/tile_sc_fifo.sv
// Single-clock show-ahead FIFO: one simple dual-port RAM feeding a
// two-stage prefetch (RAM read register, then output register).
module tile_sc_fifo #(
  parameter int DATA_WIDTH = 40,
  parameter int ADDR_WIDTH = 9,
  parameter int AFULL_TH   = 2**ADDR_WIDTH-4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic                  almost_full,
  output logic                  ovf
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH+1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         ram_cnt;
  logic                  q_valid;
  logic [DATA_WIDTH-1:0] q_data;

  logic          clr;
  logic          wr_en;
  logic          rd_en;
  logic          pop;
  logic          q_adv;
  logic          bypass;
  logic [CW-1:0] usedw_nxt;

  assign clr = rst | flush;

  // usedw never exceeds DEPTH, so its MSB alone marks full
  assign in_ready = ~usedw[ADDR_WIDTH];

  assign wr_en  = in_valid & in_ready;
  assign pop    = out_valid & out_ready;
  assign q_adv  = q_valid & (~out_valid | out_ready);
  assign rd_en  = (ram_cnt != '0) & (~q_valid | q_adv);
  assign bypass = wr_en & rd_en & (wr_ptr == rd_ptr);

  assign usedw_nxt = usedw + CW'(wr_en) - CW'(pop);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q_data <= '0;
    end else if (rd_en) begin
      q_data <= bypass ? in_data : mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      q_valid     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      usedw       <= '0;
      almost_full <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + ADDR_WIDTH'(wr_en);
      rd_ptr      <= rd_ptr + ADDR_WIDTH'(rd_en);
      ram_cnt     <= ram_cnt + CW'(wr_en) - CW'(rd_en);
      q_valid     <= rd_en | (q_valid & ~q_adv);
      usedw       <= usedw_nxt;
      almost_full <= (usedw_nxt >= CW'(AFULL_TH));
      ovf         <= ovf | (in_valid & ~in_ready);
      if (q_adv) begin
        out_valid <= 1'b1;
        out_data  <= q_data;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
